// File: rtl/e_mat_div.sv
// e_mat_div: elementwise 3x3 unsigned matrix divider.
//   Q[i][j] = A[i][j] / B[i][j], R[i][j] = A[i][j] % B[i][j]. Nine restoring
//   dividers run in lockstep, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready, A, B  operand handshake; packed 9*DW, [0][0] in MSB slice
//   out_valid/out_ready      result handshake
//   Q, R                     quotient / remainder, same packing as A/B
//   dz                       per-element divide-by-zero, bit 8 = [0][0]

// One division lane. Holds the dividend shifter, divisor, partial remainder
// and quotient shifter for a single matrix element.
module e_mat_div_lane #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] q,
  output logic [DW-1:0] r,
  output logic          bz
);
  logic [DW-1:0] a_sh, b_r, rem;
  logic [DW:0]   rem_sh, diff;
  logic          ge;

  // Partial remainder after shifting in the next dividend bit is DW+1 bits.
  // Since rem < b (or b == 0 with rem a dividend prefix), the difference
  // always fits DW+1 bits signed, so its top bit is the borrow.
  always_comb begin
    rem_sh = {rem, a_sh[DW-1]};
    diff   = rem_sh - {1'b0, b_r};
    ge     = ~diff[DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_r  <= '0;
      rem  <= '0;
      q    <= '0;
      bz   <= 1'b0;
    end else if (load) begin
      a_sh <= a;
      b_r  <= b;
      rem  <= '0;
      q    <= '0;
      bz   <= (b == '0);
    end else if (step) begin
      a_sh <= {a_sh[DW-2:0], 1'b0};
      rem  <= ge ? diff[DW-1:0] : rem_sh[DW-1:0];
      q    <= {q[DW-2:0], ge};
    end
  end

  assign r = rem;
endmodule

module e_mat_div #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9*DW-1:0] A,
  input  logic [9*DW-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9*DW-1:0] Q,
  output logic [9*DW-1:0] R,
  output logic [8:0]      dz
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, nstate;

  logic [CW-1:0] cnt;
  logic          fin;     // all DW bits done; next edge captures the result
  logic          load, step;

  // Lane k maps to packed slice k, so lane 8 is element [0][0].
  logic [8:0][DW-1:0] a_m, b_m, q_m, r_m;
  logic [8:0]         bz_m;

  assign a_m  = A;
  assign b_m  = B;
  assign load = (state == IDLE) && in_valid;
  assign step = (state == DIV) && !fin;

  for (genvar k = 0; k < 9; k++) begin : g_lane
    e_mat_div_lane #(.DW(DW)) u_lane (
      .clk (clk),
      .rst (rst),
      .load(load),
      .step(step),
      .a   (a_m[k]),
      .b   (b_m[k]),
      .q   (q_m[k]),
      .r   (r_m[k]),
      .bz  (bz_m[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = DIV;
      end
      DIV:  if (fin) nstate = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // The extra capture cycle after the last bit puts out_valid DW+1 edges
  // after acceptance; outputs then hold until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      fin <= 1'b0;
      Q   <= '0;
      R   <= '0;
      dz  <= '0;
    end else if (load) begin
      cnt <= CW'(DW-1);
      fin <= 1'b0;
    end else if (state == DIV) begin
      if (!fin) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) fin <= 1'b1;
      end else begin
        Q  <= q_m;
        R  <= r_m;
        dz <= bz_m;
      end
    end
  end
endmodule

// File: tb/tb_e_mat_div.sv
// tb_e_mat_div: directed table plus corner-case sequences and a randomized
// sweep against a behavioural divide model for e_mat_div (DW=8).
module tb_e_mat_div;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [9*DW-1:0] A, B, Q, R;
  logic [8:0]      dz;

  int n_cmp = 0;
  int n_bad = 0;

  e_mat_div #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q        (Q),
    .R        (R),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] a, b, q, r;
    logic [8:0]  dz;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] pk9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [8:0][7:0] m;
    m[8] = e0[7:0]; m[7] = e1[7:0]; m[6] = e2[7:0];
    m[5] = e3[7:0]; m[4] = e4[7:0]; m[3] = e5[7:0];
    m[2] = e6[7:0]; m[1] = e7[7:0]; m[0] = e8[7:0];
    return m;
  endfunction

  // Behavioural reference: plain / and %, with the divide-by-zero rule.
  task automatic model(input logic [71:0] a, input logic [71:0] b,
                       output logic [71:0] q, output logic [71:0] r,
                       output logic [8:0] z);
    logic [8:0][7:0] am, bm, qm, rm;
    am = a; bm = b;
    for (int k = 0; k < 9; k++) begin
      if (bm[k] == 8'd0) begin
        qm[k] = 8'hFF; rm[k] = am[k]; z[k] = 1'b1;
      end else begin
        qm[k] = am[k] / bm[k]; rm[k] = am[k] % bm[k]; z[k] = 1'b0;
      end
    end
    q = qm; r = rm;
  endtask

  // Issue one transaction, scramble inputs after acceptance, measure latency
  // and compare the result. With do_hs, out_ready must already be 1.
  task automatic run_txn(input string nm, input logic [71:0] a, input logic [71:0] b,
                         input logic [71:0] eq, input logic [71:0] er,
                         input logic [8:0] ez, input bit do_hs);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 72'(in_ready), 72'd1);
    in_valid = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk({nm, " latency"}, 72'(lat), 72'd9);
    chk({nm, " Q"}, Q, eq);
    chk({nm, " R"}, R, er);
    chk({nm, " dz"}, 72'(dz), 72'(ez));
    if (do_hs) begin
      @(posedge clk); #1;
      chk({nm, " out_valid after hs"}, 72'(out_valid), 72'd0);
      chk({nm, " in_ready after hs"}, 72'(in_ready), 72'd1);
    end
  endtask

  initial begin
    logic [71:0] eq, er, ra, rb;
    logic [8:0]  ez;
    logic [8:0][7:0] bm;

    tbl[0] = '{a: {9{8'd200}}, b: {9{8'd7}}, q: {9{8'd28}}, r: {9{8'd4}}, dz: 9'h000};
    tbl[1] = '{a: pk9(255,5,0,100,128,1,250,17,64), b: pk9(1,9,3,10,2,1,25,4,8),
               q: pk9(255,0,0,10,64,1,10,4,8),      r: pk9(0,5,0,0,0,0,0,1,0), dz: 9'h000};
    tbl[2] = '{a: pk9(42,9,9,9,9,9,9,9,0), b: pk9(0,3,3,3,3,3,3,3,0),
               q: pk9(255,3,3,3,3,3,3,3,255), r: pk9(42,0,0,0,0,0,0,0,0), dz: 9'b100000001};
    tbl[3] = '{a: pk9(7,255,254,1,0,255,100,99,3), b: pk9(7,255,255,2,255,16,7,100,1),
               q: pk9(1,1,0,0,0,15,14,0,3),        r: pk9(0,0,254,1,0,15,2,99,0), dz: 9'h000};
    tbl[4] = '{a: {9{8'd81}}, b: {9{8'd9}}, q: {9{8'd9}}, r: {9{8'd0}}, dz: 9'h000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    #2;
    chk("reset in_ready", 72'(in_ready), 72'd1);
    chk("reset out_valid", 72'(out_valid), 72'd0);
    chk("reset Q", Q, 72'd0);
    chk("reset R", R, 72'd0);
    chk("reset dz", 72'(dz), 72'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, 1'b1);

    // Backpressure: hold DONE for 5 cycles, poke in_valid, then release.
    out_ready = 1'b0;
    run_txn("bp", tbl[1].a, tbl[1].b, tbl[1].q, tbl[1].r, tbl[1].dz, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 2); A = tbl[0].a; B = tbl[0].b;
      @(posedge clk); #1;
      chk("bp out_valid held", 72'(out_valid), 72'd1);
      chk("bp Q held", Q, tbl[1].q);
      chk("bp R held", R, tbl[1].r);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp out_valid cleared", 72'(out_valid), 72'd0);
    chk("bp in_ready back", 72'(in_ready), 72'd1);
    chk("bp Q kept after hs", Q, tbl[1].q);
    @(posedge clk); #1;
    chk("bp no stray accept", 72'(in_ready), 72'd1);

    // Reset four cycles into DIV.
    @(negedge clk);
    in_valid = 1'b1; A = tbl[0].a; B = tbl[0].b;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst Q", Q, 72'd0);
    chk("midrst R", R, 72'd0);
    chk("midrst dz", 72'(dz), 72'd0);
    chk("midrst out_valid", 72'(out_valid), 72'd0);
    chk("midrst in_ready", 72'(in_ready), 72'd1);
    @(negedge clk); rst = 1'b0;
    run_txn("post_rst", tbl[4].a, tbl[4].b, tbl[4].q, tbl[4].r, tbl[4].dz, 1'b1);

    // Randomized sweep, roughly one divisor in eight forced to zero.
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 9; k++) begin
        ra[k*8 +: 8] = 8'($urandom);
        bm[k] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      rb = bm;
      model(ra, rb, eq, er, ez);
      run_txn($sformatf("rnd%0d", t), ra, rb, eq, er, ez, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
